// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Parametrised MSB-first serial pattern detector with KMP
//               fallback, saturating match counter and illegal-state recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             det,
    output logic [CNT_W-1:0] det_cnt,
    output logic             rec,
    output logic             err
);

    localparam int          c_st_w  = $clog2(PAT_W) + 1;
    localparam logic [31:0] c_pat32 = 32'(PATTERN);

    logic [c_st_w-1:0] r_st;
    logic              r_det;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rec;
    logic              r_err;

    logic [c_st_w-1:0] w_st;
    logic [31:0]       w_k;
    logic [PAT_W-1:0]  w_s;
    logic [PAT_W-1:0]  w_cand;
    logic [c_st_w-1:0] w_fb;
    logic              w_legal;
    logic              w_match;
    logic [c_st_w-1:0] w_st_nxt;
    logic              w_det_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_rec_nxt;
    logic              w_err_nxt;

    // Current prefix length as seen by all next-state logic.
    assign w_st    = r_st;
    assign w_k     = 32'(w_st);
    assign w_legal = (w_k < 32'(PAT_W));

    // s = first k pattern bits followed by the incoming bit, newest bit in the LSB.
    assign w_s = PAT_W'((c_pat32 >> (32'(PAT_W) - w_k)) << 1) | PAT_W'(in_bit);

    assign w_match = (w_k == 32'(PAT_W - 1)) && (w_s == PATTERN);

    // Candidate L: the last L bits of s equal the first L pattern bits.
    // Lengths stop at PAT_W-1, so a full match falls back to a proper prefix.
    assign w_cand[0] = 1'b1;

    for (genvar L = 1; L < PAT_W; L++) begin : g_cand
        localparam logic [PAT_W-1:0] c_mask = PAT_W'((32'd1 << L) - 32'd1);
        localparam logic [PAT_W-1:0] c_pfx  = PAT_W'(c_pat32 >> (PAT_W - L));

        assign w_cand[L] = (w_k + 32'd1 >= 32'(L)) && ((w_s & c_mask) == c_pfx);
    end

    always_comb begin
        w_fb = '0;
        for (int L = 0; L < PAT_W; L++) begin
            if (w_cand[L]) begin
                w_fb = c_st_w'(L);
            end
        end
    end

    always_comb begin
        w_st_nxt  = w_st;
        w_det_nxt = 1'b0;
        w_cnt_nxt = r_cnt;
        w_rec_nxt = 1'b0;
        w_err_nxt = r_err;
        if (clr) begin
            w_st_nxt  = '0;
            w_cnt_nxt = '0;
            w_err_nxt = 1'b0;
        end else if (!w_legal) begin
            w_st_nxt  = '0;
            w_rec_nxt = 1'b1;
            w_err_nxt = 1'b1;
        end else if (in_valid) begin
            w_st_nxt  = (w_match && !OVERLAP) ? '0 : w_fb;
            w_det_nxt = w_match;
            if (w_match && !(&r_cnt)) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st  <= '0;
            r_det <= 1'b0;
            r_cnt <= '0;
            r_rec <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_st  <= w_st_nxt;
            r_det <= w_det_nxt;
            r_cnt <= w_cnt_nxt;
            r_rec <= w_rec_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign det     = r_det;
    assign det_cnt = r_cnt;
    assign rec     = r_rec;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_param
// Description : Scoreboard bench for seq_detect_param, three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    typedef struct packed {
        logic        det;
        logic [31:0] cnt;
        logic        rec;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;

    logic       det_ov, rec_ov, err_ov;
    logic [7:0] cnt_ov;
    logic       det_no, rec_no, err_no;
    logic [7:0] cnt_no;
    logic       det_sat, rec_sat, err_sat;
    logic [1:0] cnt_sat;

    exp_t q_ov[$];
    exp_t q_no[$];
    exp_t q_sat[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: history of accepted bits since the last restart.
    localparam logic [3:0] c_pat = 4'b1101;
    logic [31:0] m_hist[3];
    int          m_hlen[3];
    int          m_cnt[3];
    logic        m_err[3];
    int          m_max[3] = '{255, 255, 3};
    logic        m_ovl[3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
        .det(det_ov), .det_cnt(cnt_ov), .rec(rec_ov), .err(err_ov));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
        .det(det_no), .det_cnt(cnt_no), .rec(rec_no), .err(err_no));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
        .det(det_sat), .det_cnt(cnt_sat), .rec(rec_sat), .err(err_sat));

    function automatic exp_t mk(logic d, logic [31:0] c, logic r, logic e);
        exp_t x;
        x.det = d;
        x.cnt = c;
        x.rec = r;
        x.err = e;
        return x;
    endfunction

    function automatic exp_t model_step(int i, logic v, logic b, logic c, logic ill);
        exp_t e;
        e = '0;
        if (c) begin
            m_hlen[i] = 0;
            m_cnt[i]  = 0;
            m_err[i]  = 1'b0;
        end else if (ill) begin
            m_hlen[i] = 0;
            m_err[i]  = 1'b1;
            e.rec     = 1'b1;
        end else if (v) begin
            m_hist[i] = {m_hist[i][30:0], b};
            m_hlen[i] = m_hlen[i] + 1;
            if (m_hlen[i] >= 4 && m_hist[i][3:0] == c_pat) begin
                e.det = 1'b1;
                if (m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
                if (!m_ovl[i]) m_hlen[i] = 0;
            end
        end
        e.cnt = 32'(m_cnt[i]);
        e.err = m_err[i];
        return e;
    endfunction

    task automatic check(string nm, exp_t got, exp_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got det=%b cnt=%0d rec=%b err=%b, expected det=%b cnt=%0d rec=%b err=%b",
                     nm, cyc, got.det, got.cnt, got.rec, got.err, exp.det, exp.cnt, exp.rec, exp.err);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q_ov.size() > 0)  check("overlap",    mk(det_ov, 32'(cnt_ov), rec_ov, err_ov), q_ov.pop_front());
            if (q_no.size() > 0)  check("nonoverlap", mk(det_no, 32'(cnt_no), rec_no, err_no), q_no.pop_front());
            if (q_sat.size() > 0) check("saturate",   mk(det_sat, 32'(cnt_sat), rec_sat, err_sat), q_sat.pop_front());
        end
    end

    task automatic step(logic v, logic b, logic c, logic ill);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = v;
        in_bit   = b;
        clr      = c;
        if (ill) begin
            force dut_ov.w_st  = 3'b110;
            force dut_no.w_st  = 3'b110;
            force dut_sat.w_st = 3'b110;
        end
        q_ov.push_back(model_step(0, v, b, c, ill));
        q_no.push_back(model_step(1, v, b, c, ill));
        q_sat.push_back(model_step(2, v, b, c, ill));
        if (ill) begin
            @(posedge clk);
            #2;
            release dut_ov.w_st;
            release dut_no.w_st;
            release dut_sat.w_st;
        end
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic reset_pulse();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        clr      = 1'b0;
        #1;
        check("async_rst_ov",  mk(det_ov, 32'(cnt_ov), rec_ov, err_ov), '0);
        check("async_rst_no",  mk(det_no, 32'(cnt_no), rec_no, err_no), '0);
        check("async_rst_sat", mk(det_sat, 32'(cnt_sat), rec_sat, err_sat), '0);
        for (int i = 0; i < 3; i++) begin
            m_hlen[i] = 0;
            m_cnt[i]  = 0;
            m_err[i]  = 1'b0;
        end
        q_ov.push_back('0);
        q_no.push_back('0);
        q_sat.push_back('0);
    endtask

    task automatic send(logic [31:0] bits, int n);
        for (int j = n - 1; j >= 0; j--) begin
            step(1'b1, bits[j], 1'b0, 1'b0);
        end
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = '0;
            m_hlen[i] = 0;
            m_cnt[i]  = 0;
            m_err[i]  = 1'b0;
        end

        // Reset and basic detect
        reset_pulse();
        send(32'b1101, 4);
        idle(2);

        // Overlapping vs non-overlapping
        send(32'b1101101, 7);
        idle(2);

        // KMP fallback, then the same with valid gaps
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send(32'b11101, 5);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Illegal-state recovery, err sticky until clr
        send(32'b11, 2);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send(32'b1101, 4);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Saturation, then clr on the completing bit
        send(32'b1101, 4);
        send(32'b1101, 4);
        send(32'b1101, 4);
        send(32'b1101, 4);
        send(32'b1101, 4);
        idle(1);
        send(32'b110, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Async reset mid-match
        send(32'b110, 3);
        reset_pulse();
        send(32'b1, 1);
        idle(1);
        send(32'b1101, 4);
        idle(2);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399, 0) == 0) begin
                reset_pulse();
            end else begin
                step(1'($urandom_range(4, 0) != 0),
                     1'($urandom_range(1, 0)),
                     1'($urandom_range(99, 0) == 0),
                     1'($urandom_range(149, 0) == 0));
            end
        end
        idle(3);

        @(posedge clk);
        #2;
        n_checks++;
        if (q_ov.size() + q_no.size() + q_sat.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0",
                     q_ov.size() + q_no.size() + q_sat.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: a generalised successor of the fixed 4-bit sequence FSMs in the advanced-FSM set. It matches an arbitrary PAT_W-bit pattern, MSB first, on a qualified serial bit stream. Overlap or non-overlap detection is selected at elaboration. It keeps a saturating detection count and detects, reports and recovers from corrupted (illegal) state-register values. It sits between a serial front end and a control or status block that consumes detect pulses and counts.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101: pattern to match, PAT_W bits wide; PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = matcher restarts from empty after each match.
- CNT_W, 8: width of the detection counter; legal range 1..32.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- clr  input  1  synchronous clear of state, counter and error flag.
- in_valid  input  1  qualifies in_bit for the current cycle.
- in_bit  input  1  serial data bit.
- det  output  1  one-cycle pulse: a full match completed on the previously accepted bit.
- det_cnt  output  CNT_W  number of detections since reset/clr; saturates at all-ones.
- rec  output  1  one-cycle pulse: an illegal state was found and recovered on the previous edge.
- err  output  1  sticky flag, set with rec, cleared only by rst or clr.

## Operation
- State register `st`, width $clog2(PAT_W)+1, holds the matched prefix length. Legal values are 0..PAT_W-1. Values PAT_W..2^width-1 are illegal, which guarantees spare codes exist for every PAT_W.
- Accepted bit = in_bit while in_valid=1. With in_valid=0 and a legal st, the block holds st, and det and rec are 0.
- Transition on an accepted bit b from legal state k:
  - Let s = the first k bits of PATTERN followed by b.
  - If k+1 = PAT_W and s equals PATTERN, it is a match. Set det=1 next cycle. Next st is the longest proper prefix of PATTERN that is also a suffix of s when OVERLAP=1, and 0 when OVERLAP=0.
  - Otherwise, next st = the length of the longest prefix of PATTERN that is a suffix of s (KMP fallback). This may be k+1, less than k+1, or 0.
- The fallback is computed combinationally by comparing all candidate lengths, with the longest match winning. No lookup table is precomputed outside the RTL.
- Illegal st, checked every edge regardless of in_valid:
  - Next st = 0; the accepted bit, if any, is discarded.
  - det=0; rec=1 next cycle; err is set.
  - The recovery path has priority over normal transitions.
- det_cnt increments by 1 on each match and holds at 2^CNT_W-1.
- clr=1, highest priority after rst: next st=0, det=0, rec=0, err=0, det_cnt=0. The bit in that cycle is discarded, even if it would complete a match or st is illegal.

## Timing
- Reset values (asynchronous, asserted immediately): st=0, det=0, det_cnt=0, rec=0, err=0.
- Reset release takes effect at the first rising clk edge after rst deasserts; there is no synchronous wait state.
- det, rec, err and det_cnt are all registered.
- det latency: det is high the cycle after the edge that samples the final pattern bit. det_cnt updates on the same edge that raises det.
- rec latency: rec is high the cycle after the edge at which st was illegal. err rises on the same edge as rec.
- Back-to-back matches with OVERLAP=1 produce det pulses on consecutive accepted-bit cycles where the pattern permits (e.g. all-ones pattern).
- in_valid gaps do not break a partial match; the match resumes on the next accepted bit.

## Test plan
- Reset and basic detect (defaults): rst pulse, then accept 1,1,0,1 on consecutive cycles -> det=1 exactly one cycle after the 4th bit; det_cnt=1; rec=0, err=0.
- Overlap (OVERLAP=1): accept 1,1,0,1,1,0,1 -> det pulses after bits 4 and 7; det_cnt=2. Repeat with OVERLAP=0 -> a single det after bit 4; det_cnt=1.
- KMP fallback (PATTERN=4'b1101): accept 1,1,1,0,1 -> st goes 1,2,2,3, then match; det after bit 5. Insert in_valid=0 gaps between bits -> same det, delayed only by the gaps.
- Illegal-state recovery: after accepting 1,1, force st=3'b110 for one edge and release it -> rec=1 for one cycle, err=1 sticky, st=0, no det. Then 1,1,0,1 -> det=1; err remains 1 until clr=1, after which err=0 and det_cnt=0.
- Saturation and clr priority (CNT_W=2): produce 5 matches -> det_cnt sticks at 3. Assert clr on the cycle the 4th pattern bit is accepted -> det stays 0 and det_cnt=0.
- Async reset mid-match: assert rst between clock edges after 1,1,0 -> all outputs are 0 immediately. After release, a lone 1 gives no det; 1,1,0,1 gives det=1.
